pulse_train_generator: RTL and testbench
========================================

# pulse_train_generator

Synthesises a programmable burst of rectangular pulses as a 14-bit signed sample stream on an AXI-Stream master, in the same sample format the ADC delivers. It is the stimulus/transmit end of the pulse-counting chain. Its output drives the DAC path or loops back into the threshold-based pulse counter, so every generated pulse crosses the counter's high threshold and then its low threshold exactly once.

## Interface
- AXIS_TDATA_WIDTH, 32, stream word width
- ADC_WIDTH, 14, sample width carried in tdata[ADC_WIDTH-1:0]
- COUNT_WIDTH, 32, width of pulse-count configuration and status
- TIMER_WIDTH, 24, width of high/low duration fields (in beats)
- HIGH_LEVEL, 14'sd8000, signed sample value during pulse high
- LOW_LEVEL, 14'sd0, signed baseline sample value

- clk  in  1  single clock, 125 MHz
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; begins a burst when sampled high in IDLE
- abort  in  1  synchronous; terminates a burst
- n_pulses  in  COUNT_WIDTH  pulses per burst
- high_cycles  in  TIMER_WIDTH  beats per pulse at HIGH_LEVEL
- low_cycles  in  TIMER_WIDTH  beats after each pulse at LOW_LEVEL
- M_AXIS_OUT_tdata  out  AXIS_TDATA_WIDTH  sample, sign-extended to full width
- M_AXIS_OUT_tvalid  out  1  stream valid
- M_AXIS_OUT_tready  in  1  downstream ready
- busy  out  1  high in HIGH or LOW state
- done  out  1  one-cycle burst-complete strobe
- pulses_sent  out  COUNT_WIDTH  completed pulses in the current or last burst

## Operation
- Beat = cycle with tvalid & tready. Timers, the state and the sample register advance only on beats, except for IDLE entry/exit, abort and DONE.
- tvalid is 0 in reset and 1 in every cycle after reset release, including IDLE, so the baseline streams continuously.
- tdata = {sign-extension, sample}. It is registered and changes only after an accepted beat or on a state change out of IDLE, DONE or abort, never while tvalid=1 and tready=0 mid-burst.
- States: IDLE, HIGH, LOW, DONE.
- IDLE: sample = LOW_LEVEL. On start=1, latch n_pulses, high_cycles and low_cycles, and clear pulses_sent.
  - If latched n_pulses==0 or high_cycles==0: go to DONE.
  - Otherwise: go to HIGH with sample = HIGH_LEVEL.
- HIGH: after high_cycles beats, pulses_sent += 1, go to LOW with sample = LOW_LEVEL.
- LOW: latched low_cycles==0 is treated as 1, so a falling edge always appears.
  - After the required LOW beats, if pulses_sent == latched n_pulses: go to DONE.
  - Otherwise: go to HIGH.
- DONE: lasts one cycle, done=1, sample = LOW_LEVEL, then go to IDLE.
- abort=1 in HIGH or LOW:
  - Next edge goes to IDLE with sample = LOW_LEVEL.
  - No done strobe.
  - pulses_sent holds the completed pulses.
  - abort has no effect in IDLE or DONE.
  - If abort and start are both high in IDLE, start wins.
- Configuration inputs are ignored after latching. Changing them mid-burst has no effect.
- Counters are unsigned, compare with ==, and never wrap within a burst.

## Timing
- Reset values: tvalid=0, tdata=sign-extended LOW_LEVEL, busy=0, done=0, pulses_sent=0, state IDLE. Reset takes effect immediately whenever it is asserted, including mid-burst.
- Start latency: the first HIGH_LEVEL sample is on tdata in the cycle after the edge that sampled start=1.
- Burst length with tready=1: n_pulses*(high_cycles+max(low_cycles,1)) beats. done is high in the cycle after the last LOW beat's edge.
- Degenerate burst (n_pulses==0 or high_cycles==0): done is high 1 cycle after the start edge.
- busy rises with the first HIGH sample. It falls in the DONE cycle, or in the cycle after an abort edge.
- start held high continuously: consecutive bursts are separated by exactly one DONE cycle and one IDLE cycle, both at LOW_LEVEL.
- pulses_sent increments on the edge that ends each HIGH phase.

## Test plan
- n=3, high=4, low=4, tready=1, start pulsed:
  - Expected sample sequence: 4×8000, 4×0, repeated 3 times, 24 beats in total.
  - done one cycle after the last beat; pulses_sent=3.
  - Looped into the pulse counter (thresholds 6000/2000), exactly 3 rising crossings are observed.
- Same configuration with tready random at 50%:
  - The accepted-beat sequence is identical to the tready=1 case.
  - tdata is stable during every stall; done follows the 24th accepted beat.
- n=0, start pulsed: no HIGH samples, done=1 one cycle after the start edge, pulses_sent=0. Repeat with n=2, high=0: same result.
- n=5, high=10, low=0, abort raised on the 3rd beat of pulse 3:
  - LOW_LEVEL on the next cycle, busy=0, no done strobe, pulses_sent=2.
  - low=0 produces a 1-beat gap between pulses.
- rst asserted asynchronously mid-HIGH: tvalid=0, tdata=0, busy=0 and pulses_sent=0 immediately. After release, baseline resumes and a new start runs a full burst.
- start held high with n=1, high=2, low=3: repeated frames of 2×8000, 3×0, 0 (DONE), 0 (IDLE); done pulses once per frame.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Programmable burst of rectangular pulses on an AXI-Stream master.
// The stream carries the baseline continuously; pulses and gaps are timed in accepted beats.
module pulse_train_generator #(
    parameter int                          AXIS_TDATA_WIDTH = 32,
    parameter int                          ADC_WIDTH        = 14,
    parameter int                          COUNT_WIDTH      = 32,
    parameter int                          TIMER_WIDTH      = 24,
    parameter logic signed [ADC_WIDTH-1:0] HIGH_LEVEL       = 14'sd8000,
    parameter logic signed [ADC_WIDTH-1:0] LOW_LEVEL        = 14'sd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [COUNT_WIDTH-1:0]      n_pulses,
    input  logic [TIMER_WIDTH-1:0]      high_cycles,
    input  logic [TIMER_WIDTH-1:0]      low_cycles,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                        M_AXIS_OUT_tvalid,
    input  logic                        M_AXIS_OUT_tready,
    output logic                        busy,
    output logic                        done,
    output logic [COUNT_WIDTH-1:0]      pulses_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [COUNT_WIDTH-1:0] n;
        logic [TIMER_WIDTH-1:0] high;
        logic [TIMER_WIDTH-1:0] low;
    } cfg_t;

    state_t                       state_q, state_d;
    cfg_t                         cfg_q, cfg_d;
    logic [TIMER_WIDTH-1:0]       timer_q, timer_d;
    logic [COUNT_WIDTH-1:0]       pulses_q, pulses_d;
    logic signed [ADC_WIDTH-1:0]  sample_q, sample_d;
    logic                         tvalid_q;

    logic                         beat;
    logic [TIMER_WIDTH-1:0]       low_eff;

    assign beat = tvalid_q & M_AXIS_OUT_tready;

    // A zero low duration still gets one baseline beat so every pulse has a falling edge.
    assign low_eff = (cfg_q.low == '0) ? TIMER_WIDTH'(1) : cfg_q.low;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        timer_d  = timer_q;
        pulses_d = pulses_q;
        sample_d = sample_q;

        unique case (state_q)
            S_IDLE: begin
                sample_d = LOW_LEVEL;
                if (start) begin
                    cfg_d.n    = n_pulses;
                    cfg_d.high = high_cycles;
                    cfg_d.low  = low_cycles;
                    pulses_d   = '0;
                    if (n_pulses == '0 || high_cycles == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_HIGH;
                        sample_d = HIGH_LEVEL;
                        timer_d  = high_cycles;
                    end
                end
            end

            S_HIGH: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    sample_d = LOW_LEVEL;
                end else if (beat) begin
                    if (timer_q == TIMER_WIDTH'(1)) begin
                        pulses_d = pulses_q + COUNT_WIDTH'(1);
                        state_d  = S_LOW;
                        sample_d = LOW_LEVEL;
                        timer_d  = low_eff;
                    end else begin
                        timer_d = timer_q - TIMER_WIDTH'(1);
                    end
                end
            end

            S_LOW: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    sample_d = LOW_LEVEL;
                end else if (beat) begin
                    if (timer_q == TIMER_WIDTH'(1)) begin
                        if (pulses_q == cfg_q.n) begin
                            state_d  = S_DONE;
                            sample_d = LOW_LEVEL;
                        end else begin
                            state_d  = S_HIGH;
                            sample_d = HIGH_LEVEL;
                            timer_d  = cfg_q.high;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_WIDTH'(1);
                    end
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                sample_d = LOW_LEVEL;
            end

            default: begin
                state_d  = S_IDLE;
                sample_d = LOW_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cfg_q    <= '0;
            timer_q  <= '0;
            pulses_q <= '0;
            sample_q <= LOW_LEVEL;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            timer_q  <= timer_d;
            pulses_q <= pulses_d;
            sample_q <= sample_d;
            tvalid_q <= 1'b1;
        end
    end

    assign M_AXIS_OUT_tdata  = {{(AXIS_TDATA_WIDTH-ADC_WIDTH){sample_q[ADC_WIDTH-1]}}, sample_q};
    assign M_AXIS_OUT_tvalid = tvalid_q;
    assign busy              = (state_q == S_HIGH) || (state_q == S_LOW);
    assign done              = (state_q == S_DONE);
    assign pulses_sent       = pulses_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: vector table, hand-written corner sequences and
// randomized bursts checked against a beat-sequence model built from the burst rules.
module tb_pulse_train_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] n_pulses = '0;
    logic [23:0] high_cycles = '0;
    logic [23:0] low_cycles = '0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        busy;
    logic        done;
    logic [31:0] pulses_sent;

    int vectors = 0;
    int miscompares = 0;

    localparam int HI = 8000;
    localparam int LO = 0;

    pulse_train_generator dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .n_pulses          (n_pulses),
        .high_cycles       (high_cycles),
        .low_cycles        (low_cycles),
        .M_AXIS_OUT_tdata  (tdata),
        .M_AXIS_OUT_tvalid (tvalid),
        .M_AXIS_OUT_tready (tready),
        .busy              (busy),
        .done              (done),
        .pulses_sent       (pulses_sent)
    );

    always #4 clk = ~clk;

    typedef struct {
        int n;
        int h;
        int l;
        int rmode;      // 0: tready always 1, 1: random 50%
        int abort_at;   // beats accepted before abort is raised, -1 for none
        int exp_beats;
        int exp_pulses;
        int exp_done;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses completed after k accepted beats of an (h, l) burst.
    function automatic int pulses_after(input int k, input int h, input int l);
        int le, p;
        le = (l == 0) ? 1 : l;
        p  = h + le;
        return k / p + (((k % p) >= h) ? 1 : 0);
    endfunction

    task automatic run_burst(input int n, input int h, input int l, input int rmode,
                             input int abort_at, input int exp_beats,
                             input int exp_pulses, input int exp_done);
        int   exp_q[$];
        int   le, beats, cyc, last_beat, crossings;
        logic armed, stalled, seen_done, aborted, ready;
        logic [31:0] prev_td;

        le = (l == 0) ? 1 : l;
        if (h > 0)
            for (int p = 0; p < n; p++) begin
                for (int i = 0; i < h; i++) exp_q.push_back(HI);
                for (int i = 0; i < le; i++) exp_q.push_back(LO);
            end

        n_pulses    = 32'(n);
        high_cycles = 24'(h);
        low_cycles  = 24'(l);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;

        beats = 0; cyc = 1; last_beat = -10; crossings = 0;
        armed = 1'b1; stalled = 1'b0; seen_done = 1'b0; aborted = 1'b0;
        prev_td = '0;
        while (cyc < 2000) begin
            // latched configuration must not follow these
            n_pulses    = $urandom;
            high_cycles = 24'($urandom);
            low_cycles  = 24'($urandom);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (!busy) break;
            if (stalled) chk("stall_hold", tdata, prev_td);
            if (abort_at >= 0 && beats == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                aborted = 1'b1;
                break;
            end
            ready  = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tready = ready;
            if (ready) begin
                if (beats < exp_q.size()) chk("beat_data", tdata, 32'(exp_q[beats]));
                else chk("extra_beat", 32'(beats), 32'(exp_q.size()));
                if (armed && $signed(tdata) >= 6000) begin
                    crossings++;
                    armed = 1'b0;
                end else if (!armed && $signed(tdata) <= 2000) begin
                    armed = 1'b1;
                end
                beats++;
                last_beat = cyc;
            end
            stalled = !ready;
            prev_td = tdata;
            @(negedge clk);
            cyc++;
        end
        tready = 1'b1;

        chk("timeout", 32'(cyc < 2000), 32'd1);
        chk("beats", 32'(beats), 32'(exp_beats));
        chk("pulses_sent", pulses_sent, 32'(exp_pulses));
        chk("done_seen", 32'(seen_done), 32'(exp_done));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_tdata", tdata, 32'(LO));
        if (seen_done) begin
            if (exp_beats > 0) chk("done_after_last_beat", 32'(cyc - last_beat), 32'd1);
            else chk("degenerate_done_latency", 32'(cyc), 32'd1);
            chk("crossings", 32'(crossings), 32'(exp_pulses));
        end
        if (aborted) chk("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n, h, l, ab, le, total, dcount;

        tbl[0] = '{3, 4, 4, 0, -1, 24, 3, 1};
        tbl[1] = '{3, 4, 4, 1, -1, 24, 3, 1};
        tbl[2] = '{0, 4, 4, 0, -1, 0, 0, 1};
        tbl[3] = '{2, 0, 3, 1, -1, 0, 0, 1};
        tbl[4] = '{5, 10, 0, 0, 24, 24, 2, 0};
        tbl[5] = '{1, 1, 0, 1, -1, 2, 1, 1};
        tbl[6] = '{2, 3, 1, 1, 4, 4, 1, 0};
        tbl[7] = '{4, 2, 0, 0, -1, 12, 4, 1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'(LO));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pulses", pulses_sent, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("baseline_tvalid", 32'(tvalid), 32'd1);
        chk("baseline_tdata", tdata, 32'(LO));

        foreach (tbl[i])
            run_burst(tbl[i].n, tbl[i].h, tbl[i].l, tbl[i].rmode, tbl[i].abort_at,
                      tbl[i].exp_beats, tbl[i].exp_pulses, tbl[i].exp_done);

        // start and abort together in IDLE: start wins, abort then stops the burst
        n_pulses = 32'd2; high_cycles = 24'd3; low_cycles = 24'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_wins_busy", 32'(busy), 32'd1);
        chk("start_wins_tdata", tdata, 32'(HI));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_first_busy", 32'(busy), 32'd0);
        chk("abort_first_tdata", tdata, 32'(LO));
        chk("abort_first_done", 32'(done), 32'd0);
        chk("abort_first_pulses", pulses_sent, 32'd0);
        @(negedge clk);

        // asynchronous reset mid-HIGH of the second pulse
        n_pulses = 32'd3; high_cycles = 24'd4; low_cycles = 24'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_tdata", tdata, 32'(HI));
        chk("pre_rst_pulses", pulses_sent, 32'd2 - 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(tvalid), 32'd0);
        chk("async_rst_tdata", tdata, 32'(LO));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_pulses", pulses_sent, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_tvalid", 32'(tvalid), 32'd1);
        run_burst(3, 4, 4, 1, -1, 24, 3, 1);

        // start held high: frames of 2xHI, 3xLO, DONE, IDLE
        n_pulses = 32'd1; high_cycles = 24'd2; low_cycles = 24'd3;
        tready = 1'b1;
        start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk("held_tdata", tdata, ((i % 7) < 2) ? 32'(HI) : 32'(LO));
            chk("held_done", 32'(done), ((i % 7) == 5) ? 32'd1 : 32'd0);
            if (done) dcount++;
        end
        start = 1'b0;
        chk("held_done_count", 32'(dcount), 32'd3);
        @(negedge clk);

        // randomized bursts against the model
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 4);
            h = $urandom_range(0, 5);
            l = $urandom_range(0, 4);
            le = (l == 0) ? 1 : l;
            total = (h == 0) ? 0 : n * (h + le);
            ab = -1;
            if (total > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(0, total - 1);
            if (ab >= 0)
                run_burst(n, h, l, 1, ab, ab, pulses_after(ab, h, l), 0);
            else
                run_burst(n, h, l, 1, -1, total, (h == 0) ? 0 : n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
